// File: rtl/axis_dense_gather_if.sv
// AXI-Stream bundle shared by every neuron result stream and the gathered vector stream.
// N is the word width in bytes.
interface axis_if #(
  parameter int N = 4
);
  logic [N*8-1:0] tdata;
  logic           tvalid;
  logic           tready;
  logic           tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_dense_gather.sv
// Gathers one word from each of M neuron streams, strictly in index order, and emits them as a
// single M-word AXI-Stream vector through one output register stage (tlast on word M-1).
module axis_dense_gather #(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic   aclk,
  input  logic   reset,
  axis_if.slave  axis_in [M],
  axis_if.master axis_out,
  output logic   error,
  output logic   busy
);
  localparam int            IW       = (M > 1) ? $clog2(M) : 1;
  localparam int            DW       = N * 8;
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  logic [IW-1:0] r_idx;
  logic          r_vld_p1;
  logic          r_last_p1;
  logic [DW-1:0] r_data_p1;
  logic          r_err;

  logic [M-1:0]  w_vld;
  logic [M-1:0]  w_last;
  logic [DW-1:0] w_data [M];
  logic          w_load;
  logic          w_acc;
  logic          w_sel_vld;
  logic          w_sel_last;
  logic [DW-1:0] w_sel_data;
  logic          w_idx_end;

  // The register can take a new word when empty or when its current word leaves this cycle.
  assign w_load    = ~r_vld_p1 | axis_out.tready;
  assign w_idx_end = (r_idx == LAST_IDX);

  for (genvar g = 0; g < M; g++) begin : g_in
    assign w_vld[g]           = axis_in[g].tvalid;
    assign w_last[g]          = axis_in[g].tlast;
    assign w_data[g]          = axis_in[g].tdata;
    assign axis_in[g].tready  = w_load & (r_idx == IW'(g));
  end

  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_data = '0;
    for (int i = 0; i < M; i++) begin
      if (r_idx == IW'(i)) begin
        w_sel_vld  = w_vld[i];
        w_sel_last = w_last[i];
        w_sel_data = w_data[i];
      end
    end
  end

  assign w_acc = w_sel_vld & w_load;

  // ---- stage p1: output register ----
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_idx     <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_data_p1 <= '0;
      r_err     <= 1'b0;
    end else if (w_acc) begin
      r_data_p1 <= w_sel_data;
      r_last_p1 <= w_idx_end;
      r_vld_p1  <= 1'b1;
      r_idx     <= w_idx_end ? '0 : r_idx + 1'b1;
      r_err     <= r_err | ~w_sel_last;
    end else if (axis_out.tready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign axis_out.tvalid = r_vld_p1;
  assign axis_out.tdata  = r_data_p1;
  assign axis_out.tlast  = r_last_p1;
  assign error           = r_err;
  assign busy            = (r_idx != '0) | r_vld_p1;
endmodule

// File: tb/tb_axis_dense_gather.sv
// Bench for axis_dense_gather: an M=4 instance and an M=1 instance, each checked against
// expectations built from the vector-gathering rules (queues of words in neuron order).
module tb_axis_dense_gather;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axis_if #(.N(4)) in4 [4] ();
  axis_if #(.N(4)) out4 ();
  axis_if #(.N(4)) in1 [1] ();
  axis_if #(.N(4)) out1 ();

  logic [3:0]  vld4, lst4, rdy4;
  logic [31:0] dat4 [4];
  logic        ordy4;
  logic        vld1, lst1, rdy1;
  logic [31:0] dat1;
  logic        ordy1;
  logic        o4_vld, o4_last, o1_vld, o1_last;
  logic [31:0] o4_data, o1_data;
  logic        err4, busy4, err1, busy1;

  for (genvar g = 0; g < 4; g++) begin : g_drv4
    assign in4[g].tvalid = vld4[g];
    assign in4[g].tdata  = dat4[g];
    assign in4[g].tlast  = lst4[g];
    assign rdy4[g]       = in4[g].tready;
  end
  assign in1[0].tvalid = vld1;
  assign in1[0].tdata  = dat1;
  assign in1[0].tlast  = lst1;
  assign rdy1          = in1[0].tready;
  assign out4.tready   = ordy4;
  assign out1.tready   = ordy1;
  assign o4_vld  = out4.tvalid;
  assign o4_data = out4.tdata;
  assign o4_last = out4.tlast;
  assign o1_vld  = out1.tvalid;
  assign o1_data = out1.tdata;
  assign o1_last = out1.tlast;

  axis_dense_gather #(.M(4), .N(4)) dut4 (
    .aclk(clk), .reset(reset), .axis_in(in4), .axis_out(out4), .error(err4), .busy(busy4)
  );
  axis_dense_gather #(.M(1), .N(4)) dut1 (
    .aclk(clk), .reset(reset), .axis_in(in1), .axis_out(out1), .error(err1), .busy(busy1)
  );

  int errs = 0;
  int checks = 0;
  logic [3:0]  hs4;
  logic        hs1;
  logic        st4;
  logic [31:0] snap_d;
  logic        snap_l;
  logic [31:0] got4_d [$];
  logic        got4_l [$];

  // One clock: handshakes sampled at the falling edge, inputs updated 1ns after the rising edge.
  task automatic step();
    logic o4_hs;
    @(negedge clk);
    hs4    = reset ? 4'b0 : (vld4 & rdy4);
    hs1    = !reset && vld1 && rdy1;
    o4_hs  = !reset && o4_vld && ordy4;
    st4    = !reset && o4_vld && !ordy4;
    snap_d = o4_data;
    snap_l = o4_last;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs4[i]) vld4[i] = 1'b0;
    if (hs1) vld1 = 1'b0;
    if (o4_hs) begin
      got4_d.push_back(snap_d);
      got4_l.push_back(snap_l);
    end
  endtask

  task automatic reset_dut();
    vld4 = '0; lst4 = 4'hF; ordy4 = 1'b1;
    vld1 = 1'b0; lst1 = 1'b1; ordy1 = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    got4_d.delete();
    got4_l.delete();
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (o4_vld !== 1'b0) begin errs++; $display("FAIL rst_tvalid: got %b expected 0", o4_vld); end
    checks++; if (o4_data !== 32'h0) begin errs++; $display("FAIL rst_tdata: got %h expected 0", o4_data); end
    checks++; if (o4_last !== 1'b0) begin errs++; $display("FAIL rst_tlast: got %b expected 0", o4_last); end
    checks++; if (err4 !== 1'b0) begin errs++; $display("FAIL rst_error: got %b expected 0", err4); end
    checks++; if (busy4 !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", busy4); end
    checks++; if (rdy4 !== 4'b0001) begin errs++; $display("FAIL rst_tready: got %b expected 0001", rdy4); end
    checks++; if (rdy1 !== 1'b1 || o1_vld !== 1'b0) begin errs++; $display("FAIL rst_m1: got rdy=%b vld=%b expected 1 0", rdy1, o1_vld); end
  endtask

  task automatic test_ordered();
    logic [31:0] w [4];
    w[0] = 32'h3F800000; w[1] = 32'h40000000; w[2] = 32'h40400000; w[3] = 32'h40800000;
    for (int i = 0; i < 4; i++) dat4[i] = w[i];
    lst4 = 4'hF; ordy4 = 1'b1; vld4 = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (o4_vld !== 1'b1 || o4_data !== w[k-1] || o4_last !== (k == 4)) begin
        errs++;
        $display("FAIL ordered_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", k, o4_vld, o4_data, o4_last, w[k-1], (k == 4));
      end
      checks++; if (busy4 !== 1'b1) begin errs++; $display("FAIL ordered_busy%0d: got %b expected 1", k, busy4); end
    end
    step();
    checks++; if (o4_vld !== 1'b0 || busy4 !== 1'b0) begin errs++; $display("FAIL ordered_drain: got v=%b busy=%b expected 0 0", o4_vld, busy4); end
  endtask

  task automatic test_out_of_order();
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    got4_d.delete(); got4_l.delete();
    dat4[2] = w[2]; vld4 = 4'b0100; ordy4 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if (o4_vld !== 1'b0 || rdy4 !== 4'b0001 || busy4 !== 1'b0) begin
        errs++; $display("FAIL ooo_wait%0d: got v=%b rdy=%b busy=%b expected 0 0001 0", j, o4_vld, rdy4, busy4);
      end
    end
    dat4[0] = w[0]; dat4[1] = w[1]; dat4[3] = w[3]; vld4 = 4'hF;
    for (int j = 1; j <= 6; j++) begin
      step();
      checks++;
      if (rdy4[2] !== (j == 2)) begin errs++; $display("FAIL ooo_tready2_step%0d: got %b expected %b", j, rdy4[2], (j == 2)); end
    end
    checks++;
    if (got4_d.size() != 4) begin
      errs++; $display("FAIL ooo_count: got %0d expected 4", got4_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got4_d[i] !== w[i] || got4_l[i] !== (i == 3)) begin
          errs++; $display("FAIL ooo_word%0d: got d=%h l=%b expected d=%h l=%b", i, got4_d[i], got4_l[i], w[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] vdat [100][4];
    logic [31:0] exp_q [$];
    int nv [4];
    int n;
    logic [31:0] d;
    logic l;
    for (int v = 0; v < 100; v++)
      for (int i = 0; i < 4; i++) begin
        vdat[v][i] = $urandom;
        exp_q.push_back(vdat[v][i]);
      end
    for (int i = 0; i < 4; i++) nv[i] = 0;
    n = 0;
    got4_d.delete(); got4_l.delete();
    lst4 = 4'hF;
    for (int c = 0; c < 4000 && n < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (!vld4[i] && nv[i] < 100 && $urandom_range(0, 9) < 7) begin
          dat4[i] = vdat[nv[i]][i];
          vld4[i] = 1'b1;
        end
      ordy4 = 1'($urandom_range(0, 1));
      step();
      for (int i = 0; i < 4; i++) if (hs4[i]) nv[i]++;
      if (st4) begin
        checks++;
        if (o4_vld !== 1'b1 || o4_data !== snap_d || o4_last !== snap_l) begin
          errs++; $display("FAIL rand_stable_c%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", c, o4_vld, o4_data, o4_last, snap_d, snap_l);
        end
      end
      while (got4_d.size() > 0) begin
        d = got4_d.pop_front();
        l = got4_l.pop_front();
        checks++;
        if (d !== exp_q[n] || l !== ((n % 4) == 3)) begin
          errs++; $display("FAIL rand_word%0d: got d=%h l=%b expected d=%h l=%b", n, d, l, exp_q[n], ((n % 4) == 3));
        end
        n++;
      end
    end
    checks++;
    if (n != 400) begin errs++; $display("FAIL rand_count: got %0d expected 400", n); end
    ordy4 = 1'b1;
    step();
  endtask

  task automatic test_error();
    logic [31:0] w [4];
    reset_dut();
    for (int i = 0; i < 4; i++) begin w[i] = $urandom; dat4[i] = w[i]; end
    lst4 = 4'b1101; vld4 = 4'hF;
    step();
    checks++; if (err4 !== 1'b0) begin errs++; $display("FAIL err_before: got %b expected 0", err4); end
    step();
    checks++; if (err4 !== 1'b1) begin errs++; $display("FAIL err_set: got %b expected 1", err4); end
    for (int j = 0; j < 3; j++) step();
    checks++;
    if (got4_d.size() != 4) begin
      errs++; $display("FAIL err_count: got %0d expected 4", got4_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got4_d[i] !== w[i] || got4_l[i] !== (i == 3)) begin
          errs++; $display("FAIL err_word%0d: got d=%h l=%b expected d=%h l=%b", i, got4_d[i], got4_l[i], w[i], (i == 3));
        end
      end
    end
    lst4 = 4'hF;
    for (int i = 0; i < 4; i++) dat4[i] = $urandom;
    vld4 = 4'hF;
    for (int j = 0; j < 6; j++) step();
    checks++; if (err4 !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b expected 1", err4); end
    reset_dut();
    checks++; if (err4 !== 1'b0) begin errs++; $display("FAIL err_cleared: got %b expected 0", err4); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a [4];
    logic [31:0] b [4];
    reset_dut();
    for (int i = 0; i < 4; i++) begin a[i] = $urandom; b[i] = $urandom; dat4[i] = a[i]; end
    vld4 = 4'hF; ordy4 = 1'b1;
    step();
    step();
    ordy4 = 1'b0;
    checks++; if (o4_vld !== 1'b1 || o4_data !== a[1]) begin errs++; $display("FAIL mid_held: got v=%b d=%h expected v=1 d=%h", o4_vld, o4_data, a[1]); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (o4_vld !== 1'b0 || busy4 !== 1'b0) begin errs++; $display("FAIL mid_drop: got v=%b busy=%b expected 0 0", o4_vld, busy4); end
    checks++; if (rdy4 !== 4'b0001) begin errs++; $display("FAIL mid_idx0: got tready=%b expected 0001", rdy4); end
    got4_d.delete(); got4_l.delete();
    for (int i = 0; i < 4; i++) dat4[i] = b[i];
    vld4 = 4'hF; ordy4 = 1'b1;
    for (int j = 0; j < 6; j++) step();
    checks++;
    if (got4_d.size() != 4) begin
      errs++; $display("FAIL mid_count: got %0d expected 4", got4_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got4_d[i] !== b[i] || got4_l[i] !== (i == 3)) begin
          errs++; $display("FAIL mid_word%0d: got d=%h l=%b expected d=%h l=%b", i, got4_d[i], got4_l[i], b[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] lst [16];
    int p;
    for (int i = 0; i < 16; i++) lst[i] = $urandom;
    p = 0;
    ordy1 = 1'b1; lst1 = 1'b1; dat1 = lst[0]; vld1 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      if (hs1) begin
        p++;
        if (p < 16) begin dat1 = lst[p]; vld1 = 1'b1; end
      end
      checks++;
      if (o1_vld !== 1'b1 || o1_data !== lst[c] || o1_last !== 1'b1) begin
        errs++; $display("FAIL m1_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=1", c, o1_vld, o1_data, o1_last, lst[c]);
      end
    end
    step();
    checks++; if (o1_vld !== 1'b0 || err1 !== 1'b0) begin errs++; $display("FAIL m1_drain: got v=%b err=%b expected 0 0", o1_vld, err1); end
  endtask

  initial begin
    reset = 1'b1;
    vld4 = '0; lst4 = 4'hF; ordy4 = 1'b1;
    for (int i = 0; i < 4; i++) dat4[i] = '0;
    vld1 = 1'b0; lst1 = 1'b1; dat1 = '0; ordy1 = 1'b1;
    #1;
    test_reset();
    test_ordered();
    test_out_of_order();
    test_random();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
